// File: rtl/fetch_master.sv
// Nine-state fetch sequencer for a 4-bit split-bus ROM/RAM system: three address nibbles out, two data nibbles in.
// Optional FETCH_CNT_EN adds a free-running 16-bit count of completed fetches on fetch_count.
module fetch_master (
    input  logic        clock,
    input  logic        reset,
    input  logic        halt,
    input  logic        req,
    input  logic [11:0] addr,
    output logic        ready,
    output logic        busy,
    output logic [7:0]  rdata,
    output logic        ack,
    input  logic [3:0]  data_i,
    output logic [3:0]  data_o,
    output logic        data_en,
    output logic        sync,
`ifdef FETCH_CNT_EN
    output logic [15:0] fetch_count,
`endif
    output logic        rom_cmd
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_A1   = 4'd1;
    localparam logic [3:0] S_A2   = 4'd2;
    localparam logic [3:0] S_A3   = 4'd3;
    localparam logic [3:0] S_M1   = 4'd4;
    localparam logic [3:0] S_M2   = 4'd5;
    localparam logic [3:0] S_X1   = 4'd6;
    localparam logic [3:0] S_X2   = 4'd7;
    localparam logic [3:0] S_X3   = 4'd8;

    logic [3:0]  state;
    logic [3:0]  state_nxt;
    logic [11:0] addr_q;
    logic        accept;

    // Acceptance happens only at the X3 edge; IDLE merely jumps to X3 so the request is re-sampled there.
    assign accept = (state == S_X3) && req && !halt;

    always_comb begin
        state_nxt = state;
        if (!halt) begin
            case (state)
                S_IDLE:  state_nxt = req ? S_X3 : S_IDLE;
                S_A1:    state_nxt = S_A2;
                S_A2:    state_nxt = S_A3;
                S_A3:    state_nxt = S_M1;
                S_M1:    state_nxt = S_M2;
                S_M2:    state_nxt = S_X1;
                S_X1:    state_nxt = S_X2;
                S_X2:    state_nxt = S_X3;
                S_X3:    state_nxt = req ? S_A1 : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= addr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (!halt) begin
            if (state == S_M1) begin
                rdata[7:4] <= data_i;
            end
            if (state == S_M2) begin
                rdata[3:0] <= data_i;
            end
        end
    end

    // Bus-side outputs decode from the state alone, so an asynchronous reset clears them at once.
    always_comb begin
        data_en = 1'b0;
        data_o  = '0;
        case (state)
            S_A1: begin
                data_en = 1'b1;
                data_o  = addr_q[3:0];
            end
            S_A2: begin
                data_en = 1'b1;
                data_o  = addr_q[7:4];
            end
            S_A3: begin
                data_en = 1'b1;
                data_o  = addr_q[11:8];
            end
            default: begin
                data_en = 1'b0;
                data_o  = '0;
            end
        endcase
    end

    assign rom_cmd = (state == S_A3);
    assign ready   = (state == S_X3);
    assign sync    = (state == S_X3) && req;
    assign busy    = (state != S_IDLE);
    assign ack     = (state == S_X1) && !halt;

`ifdef FETCH_CNT_EN
    logic [15:0] fetch_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
        end else if (ack) begin
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_master.sv
// Self-checking bench for fetch_master: vector table, directed corner sequences and a randomized run
// against a fetch-timeline reference model.
module tb_fetch_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        halt;
    logic        req;
    logic [11:0] addr;
    logic        ready;
    logic        busy;
    logic [7:0]  rdata;
    logic        ack;
    logic [3:0]  data_i;
    logic [3:0]  data_o;
    logic        data_en;
    logic        sync;
    logic        rom_cmd;
`ifdef FETCH_CNT_EN
    logic [15:0] fetch_count;
`endif

    fetch_master dut (
        .clock   (clock),
        .reset   (reset),
        .halt    (halt),
        .req     (req),
        .addr    (addr),
        .ready   (ready),
        .busy    (busy),
        .rdata   (rdata),
        .ack     (ack),
        .data_i  (data_i),
        .data_o  (data_o),
        .data_en (data_en),
        .sync    (sync),
`ifdef FETCH_CNT_EN
        .fetch_count (fetch_count),
`endif
        .rom_cmd (rom_cmd)
    );

    always #5 clock = ~clock;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned edges   = 0;
    int unsigned tot_ack = 0;
    int unsigned tot_en  = 0;
    int unsigned ack_q[$];
    int unsigned sync_q[$];

    // Reference model: a fetch is a timeline of 8 slots after acceptance
    // (0-2 address nibbles, 3-4 data nibbles, 5 completion, 7 the re-sample slot).
    bit          m_idle;
    int unsigned m_slot;
    logic [11:0] m_addr;
    logic [7:0]  m_rdata;
    logic [15:0] m_cnt;

    typedef struct {
        logic        req;
        logic [11:0] addr;
        logic [3:0]  din;
        logic        en;
        logic [3:0]  dout;
        logic        rom;
        logic        sync;
        logic        ack;
        logic        busy;
        logic        ready;
        logic [7:0]  rdata;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edges);
    endtask

    task automatic model_reset();
        m_idle  = 1'b1;
        m_slot  = 0;
        m_addr  = '0;
        m_rdata = '0;
        m_cnt   = '0;
    endtask

    task automatic do_reset();
        halt = 1'b0; req = 1'b0; addr = '0; data_i = '0;
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(posedge clock); #1;
        edges = 0; tot_ack = 0; tot_en = 0;
        ack_q.delete(); sync_q.delete();
    endtask

    task automatic cyc(input logic h, input logic r, input logic [11:0] a, input logic [3:0] d);
        logic        e_busy, e_ready, e_en, e_rom, e_ack;
        logic [11:0] sh;
        logic [3:0]  e_do;
        halt = h; req = r; addr = a; data_i = d;
        #1;
        e_busy  = !m_idle;
        e_ready = !m_idle && (m_slot == 7);
        e_en    = !m_idle && (m_slot < 3);
        sh      = m_addr >> (4 * m_slot);
        e_do    = e_en ? sh[3:0] : 4'h0;
        e_rom   = !m_idle && (m_slot == 2);
        e_ack   = !m_idle && (m_slot == 5) && !h;
        chk("busy",    {15'd0, busy},    {15'd0, e_busy});
        chk("ready",   {15'd0, ready},   {15'd0, e_ready});
        chk("sync",    {15'd0, sync},    {15'd0, e_ready && r});
        chk("data_en", {15'd0, data_en}, {15'd0, e_en});
        chk("data_o",  {12'd0, data_o},  {12'd0, e_do});
        chk("rom_cmd", {15'd0, rom_cmd}, {15'd0, e_rom});
        chk("ack",     {15'd0, ack},     {15'd0, e_ack});
        chk("rdata",   {8'd0, rdata},    {8'd0, m_rdata});
`ifdef FETCH_CNT_EN
        chk("fetch_count", fetch_count, m_cnt);
`endif
        if (ack) begin ack_q.push_back(edges); tot_ack++; end
        if (data_en) tot_en++;
        if (sync) sync_q.push_back(edges);
        @(posedge clock);
        edges++;
        if (!h) begin
            if (e_ack) m_cnt = m_cnt + 16'd1;
            if (m_idle) begin
                if (r) begin m_idle = 1'b0; m_slot = 7; end
            end else if (m_slot == 7) begin
                if (r) begin m_addr = a; m_slot = 0; end
                else m_idle = 1'b1;
            end else begin
                if (m_slot == 3) m_rdata[7:4] = d;
                if (m_slot == 4) m_rdata[3:0] = d;
                m_slot++;
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; halt = 1'b0; req = 1'b0; addr = '0; data_i = '0;
        #3;
        chk("rst_busy",    {15'd0, busy},    16'd0);
        chk("rst_data_en", {15'd0, data_en}, 16'd0);
        chk("rst_rdata",   {8'd0, rdata},    16'd0);
        chk("rst_ack",     {15'd0, ack},     16'd0);

        // Single fetch of 0x123 with 0xA then 0x5 returned.
        tbl[0]  = '{1'b1, 12'h123, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 12'h123, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[2]  = '{1'b0, 12'hFFF, 4'h0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 12'hFFF, 4'h0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 12'hFFF, 4'h0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 12'hFFF, 4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 12'hFFF, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA0};
        tbl[7]  = '{1'b0, 12'hFFF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
        tbl[8]  = '{1'b0, 12'hFFF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
        tbl[9]  = '{1'b0, 12'hFFF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[10] = '{1'b0, 12'hFFF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            req = tbl[i].req; addr = tbl[i].addr; data_i = tbl[i].din; halt = 1'b0;
            #1;
            chk($sformatf("tbl%0d_en", i),    {15'd0, data_en}, {15'd0, tbl[i].en});
            chk($sformatf("tbl%0d_do", i),    {12'd0, data_o},  {12'd0, tbl[i].dout});
            chk($sformatf("tbl%0d_rom", i),   {15'd0, rom_cmd}, {15'd0, tbl[i].rom});
            chk($sformatf("tbl%0d_sync", i),  {15'd0, sync},    {15'd0, tbl[i].sync});
            chk($sformatf("tbl%0d_ack", i),   {15'd0, ack},     {15'd0, tbl[i].ack});
            chk($sformatf("tbl%0d_busy", i),  {15'd0, busy},    {15'd0, tbl[i].busy});
            chk($sformatf("tbl%0d_ready", i), {15'd0, ready},   {15'd0, tbl[i].ready});
            chk($sformatf("tbl%0d_rdata", i), {8'd0, rdata},    {8'd0, tbl[i].rdata});
            @(posedge clock); #1;
        end

        // Back-to-back with req held: 0x010 then 0x2FF.
        do_reset();
        begin
            bit first_taken = 1'b0;
            for (int i = 0; i < 24; i++) begin
                cyc(1'b0, 1'b1, first_taken ? 12'h2FF : 12'h010, 4'($urandom_range(0, 15)));
                if (sync_q.size() > 0) first_taken = 1'b1;
            end
        end
        chk("b2b_ack_count", 16'(ack_q.size() >= 2), 16'd1);
        if (ack_q.size() >= 2) begin
            chk("b2b_ack_latency", 16'(ack_q[0] - 1), 16'd6);
            chk("b2b_ack_gap",     16'(ack_q[1] - ack_q[0]), 16'd8);
        end
        chk("b2b_sync_count", 16'(sync_q.size() >= 2), 16'd1);
        if (sync_q.size() >= 2) chk("b2b_sync_gap", 16'(sync_q[1] - sync_q[0]), 16'd8);

        // Withdrawal: req for one IDLE cycle only.
        do_reset();
        cyc(1'b0, 1'b1, 12'h456, 4'h0);
        req = 1'b0; #1;
        chk("wd_ready", {15'd0, ready}, 16'd1);
        chk("wd_sync",  {15'd0, sync},  16'd0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 12'h456, 4'h0);
        chk("wd_no_en",  16'(tot_en),  16'd0);
        chk("wd_no_ack", 16'(tot_ack), 16'd0);
        chk("wd_idle",   {15'd0, busy}, 16'd0);

        // Halt for three cycles in M1.
        do_reset();
        cyc(1'b0, 1'b1, 12'h123, 4'h0);
        cyc(1'b0, 1'b1, 12'h123, 4'h0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 12'hFFF, 4'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 12'hFFF, 4'($urandom_range(0, 15)));
        cyc(1'b0, 1'b0, 12'hFFF, 4'hA);
        cyc(1'b0, 1'b0, 12'hFFF, 4'h5);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 12'hFFF, 4'h0);
        chk("halt_ack_count", 16'(ack_q.size()), 16'd1);
        if (ack_q.size() >= 1) chk("halt_ack_latency", 16'(ack_q[0] - 1), 16'd9);
        chk("halt_rdata", {8'd0, rdata}, 16'h00A5);

        // Reset asserted mid-cycle in A2.
        do_reset();
        cyc(1'b0, 1'b1, 12'h7BC, 4'h0);
        cyc(1'b0, 1'b1, 12'h7BC, 4'h0);
        cyc(1'b0, 1'b0, 12'h7BC, 4'h0);
        chk("a2_en_before", {15'd0, data_en}, 16'd1);
        reset = 1'b1; #1;
        chk("rst_a2_en",   {15'd0, data_en}, 16'd0);
        chk("rst_a2_do",   {12'd0, data_o},  16'd0);
        chk("rst_a2_busy", {15'd0, busy},    16'd0);
        chk("rst_a2_rom",  {15'd0, rom_cmd}, 16'd0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(posedge clock); #1;
        tot_ack = 0;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 12'h000, 4'h0);
        chk("rst_a2_no_ack", 16'(tot_ack), 16'd0);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cyc(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
                12'($urandom), 4'($urandom));
        end

`ifdef FETCH_CNT_EN
        // Counter wrap after 65536 completed fetches.
        do_reset();
        begin
            int unsigned seen = 0;
            halt = 1'b0; req = 1'b1; addr = 12'h321;
            for (int i = 0; i < 600000 && seen < 65535; i++) begin
                @(posedge clock); #1;
                if (ack) seen++;
            end
            @(posedge clock); #1;
            chk("cnt_ffff", fetch_count, 16'hFFFF);
            for (int i = 0; i < 20 && seen < 65536; i++) begin
                @(posedge clock); #1;
                if (ack) seen++;
            end
            @(posedge clock); #1;
            chk("cnt_wrap", fetch_count, 16'h0000);
            req = 1'b0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
